dac_unpack_x2: RTL and testbench

- Width down-converter on the DAC/ADC streaming path, the opposite direction to the 128→256 packer.
- Accepts one 256-bit AXI4-Stream word per transfer and emits it as two consecutive 128-bit beats.
- Single clock domain (aclk, 375 MHz), sustaining one output beat per cycle.
- Used wherever a 256-bit DAC-format stream must feed a 128-bit ADC-format consumer, e.g. loopback into ADC capture inputs.
- A resync strobe (SYSREF-derived) realigns beat phase by discarding untransferred halves.

---
 rtl/dac_unpack_x2_pkg.sv | 18 +
 rtl/dac_unpack_x2_if.sv | 13 +
 rtl/dac_unpack_x2.sv | 125 ++++++++++++
 tb/tb_dac_unpack_x2.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_unpack_x2_pkg.sv
// Shared types and helpers for the 256->128 stream unpacker.
//   unpack_state_t : beat-phase state of the unpacker
//   half_sel()     : picks which half of the held word is on the output
package dac_unpack_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } unpack_state_t;

  // Returns 1'b0 for the lower half, 1'b1 for the upper half.
  // phase 0 is the first beat of a word, phase 1 the second.
  function automatic logic half_sel(input logic low_first, input logic phase);
    return phase ^ ~low_first;
  endfunction

endpackage

// File: rtl/dac_unpack_x2_if.sv
// AXI4-Stream style data channel (tdata/tvalid/tready).
//   master : drives tdata, tvalid; receives tready
//   slave  : receives tdata, tvalid; drives tready
interface dac_unpack_x2_if #(
  parameter int W = 128
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_unpack_x2.sv
// Width down-converter: each IN_WIDTH-bit input word is emitted as two
// consecutive IN_WIDTH/2-bit beats. A resync strobe discards any half not
// yet transferred and realigns to an empty state.
// Ports:
//   aclk        stream clock
//   reset       synchronous active-high reset
//   s_axis      slave stream, IN_WIDTH-bit words
//   m_axis      master stream, IN_WIDTH/2-bit beats
//   resync      single-cycle realign strobe (aclk domain)
//   drop_count  saturating count of resync events that discarded data
module dac_unpack_x2
  import dac_unpack_pkg::*;
#(
  parameter int IN_WIDTH  = 256,
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 reset,
  dac_unpack_x2_if.slave       s_axis,
  dac_unpack_x2_if.master      m_axis,
  input  logic                 resync,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int OUT_WIDTH = IN_WIDTH / 2;

  unpack_state_t         state_r;
  logic [IN_WIDTH-1:0]   hold_r;
  logic [CNT_WIDTH-1:0]  drop_count_r;

  logic                  s_hs_s;
  logic                  m_hs_s;
  logic                  drop_s;
  logic                  sel_s;
  logic [OUT_WIDTH-1:0]  m_data_s;

  // Ready only when the holding register is free now or frees this cycle;
  // never depends on s_axis.tvalid.
  assign s_axis.tready = !resync &&
                         ((state_r == ST_EMPTY) ||
                          ((state_r == ST_SECOND) && m_axis.tready));

  assign m_axis.tvalid = (state_r != ST_EMPTY);
  assign m_axis.tdata  = m_data_s;
  assign drop_count    = drop_count_r;

  assign s_hs_s = s_axis.tvalid && s_axis.tready;
  assign m_hs_s = m_axis.tvalid && m_axis.tready;

  // A resync loses data unless the only pending half transfers this cycle.
  assign drop_s = resync &&
                  ((state_r == ST_FIRST) ||
                   ((state_r == ST_SECOND) && !m_axis.tready));

  // Output half selection from the held word.
  always_comb begin
    m_data_s = '0;
    sel_s    = half_sel(LOW_FIRST, (state_r == ST_SECOND));
    if (sel_s) begin
      m_data_s = hold_r[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin
      m_data_s = hold_r[OUT_WIDTH-1:0];
    end
  end

  // Word holding register; contents are don't-care while EMPTY.
  always_ff @(posedge aclk) begin
    if (s_hs_s) begin
      hold_r <= s_axis.tdata;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Beat-phase state machine; resync overrides normal transitions.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else if (resync) begin
      state_r <= ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (s_hs_s) begin
            state_r <= ST_FIRST;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_FIRST: begin
          if (m_hs_s) begin
            state_r <= ST_SECOND;
          end else begin
            state_r <= ST_FIRST;
          end
        end
        ST_SECOND: begin
          if (m_hs_s && s_hs_s) begin
            state_r <= ST_FIRST;
          end else if (m_hs_s) begin
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_SECOND;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of resync events that threw data away.
  always_ff @(posedge aclk) begin
    if (reset) begin
      drop_count_r <= '0;
    end else if (drop_s && (drop_count_r != {CNT_WIDTH{1'b1}})) begin
      drop_count_r <= drop_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

endmodule

// File: tb/tb_dac_unpack_x2.sv
// Self-checking bench for dac_unpack_x2. Main instance uses defaults
// (LOW_FIRST=1, CNT_WIDTH=16); a second instance uses LOW_FIRST=0 and a
// 4-bit counter so saturation can be reached quickly.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit
// later, before the next rising edge.
module tb_dac_unpack_x2;

  logic        clk;
  logic        reset;
  logic        resync;
  logic        resync1;
  logic [15:0] drop_count;
  logic [3:0]  drop_count1;

  dac_unpack_x2_if #(.W(256)) s_if ();
  dac_unpack_x2_if #(.W(128)) m_if ();
  dac_unpack_x2_if #(.W(256)) s1_if ();
  dac_unpack_x2_if #(.W(128)) m1_if ();

  dac_unpack_x2 u_dut (
    .aclk       (clk),
    .reset      (reset),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .resync     (resync),
    .drop_count (drop_count)
  );

  dac_unpack_x2 #(.IN_WIDTH(256), .LOW_FIRST(1'b0), .CNT_WIDTH(4)) u_dut_hi (
    .aclk       (clk),
    .reset      (reset),
    .s_axis     (s1_if),
    .m_axis     (m1_if),
    .resync     (resync1),
    .drop_count (drop_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] rx[$];
  logic [127:0] exp_q[$];
  logic         stall_r = 1'b0;
  logic [127:0] prev_data = '0;
  logic         s_hs = 1'b0;
  logic         s_rdy_seen = 1'b0;
  int           cyc_n = 0;
  int           first_beat = -1;
  int           last_beat = -1;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp_v);
    end
  endtask

  function automatic logic [255:0] word_of(input int i);
    logic [127:0] lo;
    logic [127:0] hi;
    lo = {96'hA5A5_0000_0000_0000_0000_0000, 32'(i)};
    hi = {96'h5A5A_FFFF_0000_0000_0000_0000, 32'(i)};
    return {hi, lo};
  endfunction

  // One clock cycle on the main instance: inputs already set by the caller.
  task automatic cyc();
    #1;
    if (stall_r) begin
      chk("valid_held", {255'd0, m_if.tvalid}, 256'd1);
      chk("data_stable", {128'd0, m_if.tdata}, {128'd0, prev_data});
    end
    stall_r   = m_if.tvalid && !m_if.tready && !resync && !reset;
    prev_data = m_if.tdata;
    if (m_if.tvalid && m_if.tready) begin
      rx.push_back(m_if.tdata);
      if (first_beat < 0) first_beat = cyc_n;
      last_beat = cyc_n;
    end
    s_rdy_seen = s_if.tready;
    s_hs       = s_if.tvalid && s_if.tready;
    cyc_n++;
    @(negedge clk);
  endtask

  // Stream n words starting at word_of(base); pct = % of cycles m tready high.
  task automatic run_stream(input int n, input int pct, input int base, input bit check_duty);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    rx.delete();
    exp_q.delete();
    first_beat = -1;
    while (((idx < n) || (rx.size() < 2 * n)) && (guard < 20000)) begin
      s_if.tvalid = (idx < n);
      s_if.tdata  = word_of(base + idx);
      m_if.tready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      cyc();
      if (check_duty && (idx < n)) begin
        chk("s_tready_toggle", {255'd0, s_rdy_seen}, {255'd0, (guard % 2 == 0)});
      end
      if (s_hs) begin
        exp_q.push_back(word_of(base + idx)[127:0]);
        exp_q.push_back(word_of(base + idx)[255:128]);
        idx++;
      end
      guard++;
    end
    s_if.tvalid = 1'b0;
    chk("stream_timeout", {255'd0, (guard < 20000)}, 256'd1);
    chk("beat_count", 256'(rx.size()), 256'(2 * n));
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      chk("beat_data", {128'd0, rx[i]}, {128'd0, exp_q[i]});
    end
    if (check_duty) begin
      chk("no_bubbles", 256'(last_beat - first_beat), 256'(2 * n - 1));
    end
  endtask

  // Load one word into the main instance (EMPTY -> FIRST) with m tready low.
  task automatic load_word(input logic [255:0] w);
    s_if.tvalid = 1'b1;
    s_if.tdata  = w;
    m_if.tready = 1'b0;
    cyc();
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    logic [255:0] w;
    reset = 1'b1;
    resync = 1'b0;
    resync1 = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    s1_if.tvalid = 1'b0;
    s1_if.tdata  = '0;
    m1_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_tvalid", {255'd0, m_if.tvalid}, 256'd0);
    chk("rst_drop", 256'(drop_count), 256'd0);
    chk("rst_drop_hi", 256'(drop_count1), 256'd0);
    cyc();
    chk("rst_s_tready", {255'd0, s_rdy_seen}, 256'd1);

    // Single word, lower half first
    w = {{8{16'hBBBB}}, {8{16'hAAAA}}};
    s_if.tvalid = 1'b1;
    s_if.tdata  = w;
    m_if.tready = 1'b1;
    cyc();
    s_if.tvalid = 1'b0;
    chk("single_v0", {255'd0, m_if.tvalid}, 256'd1);
    chk("single_d0", {128'd0, m_if.tdata}, {128'd0, {8{16'hAAAA}}});
    cyc();
    chk("single_v1", {255'd0, m_if.tvalid}, 256'd1);
    chk("single_d1", {128'd0, m_if.tdata}, {128'd0, {8{16'hBBBB}}});
    cyc();
    chk("single_v2", {255'd0, m_if.tvalid}, 256'd0);
    chk("single_drop", 256'(drop_count), 256'd0);

    // Back-to-back streaming, 32 words
    run_stream(32, 100, 0, 1'b1);

    // Random backpressure, 30% ready, 200 words
    run_stream(200, 30, 100, 1'b0);

    // Resync in FIRST without m handshake: word dropped
    load_word(word_of(400));
    chk("rs1_loaded", {255'd0, m_if.tvalid}, 256'd1);
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk("rs1_drop", 256'(drop_count), 256'd1);
    chk("rs1_empty", {255'd0, m_if.tvalid}, 256'd0);
    run_stream(1, 100, 401, 1'b0);

    // Resync in SECOND with m handshake: no drop
    load_word(word_of(410));
    m_if.tready = 1'b1;
    cyc();
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk("rs2_drop", 256'(drop_count), 256'd1);
    chk("rs2_empty", {255'd0, m_if.tvalid}, 256'd0);

    // Resync in EMPTY: no drop, s tready held low
    s_if.tvalid = 1'b1;
    s_if.tdata  = word_of(420);
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    s_if.tvalid = 1'b0;
    chk("rs3_tready", {255'd0, s_rdy_seen}, 256'd0);
    chk("rs3_drop", 256'(drop_count), 256'd1);
    chk("rs3_empty", {255'd0, m_if.tvalid}, 256'd0);

    // Resync in SECOND without m handshake: drop
    load_word(word_of(430));
    m_if.tready = 1'b1;
    cyc();
    m_if.tready = 1'b0;
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk("rs4_drop", 256'(drop_count), 256'd2);

    // Reset while in SECOND with a pending half
    load_word(word_of(440));
    m_if.tready = 1'b1;
    cyc();
    m_if.tready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst2_tvalid", {255'd0, m_if.tvalid}, 256'd0);
    chk("rst2_drop", 256'(drop_count), 256'd0);
    cyc();
    chk("rst2_s_tready", {255'd0, s_rdy_seen}, 256'd1);
    run_stream(3, 100, 450, 1'b0);

    // Upper half first on the second instance
    w = {{8{16'h1234}}, {8{16'h5678}}};
    s1_if.tvalid = 1'b1;
    s1_if.tdata  = w;
    m1_if.tready = 1'b1;
    @(negedge clk);
    s1_if.tvalid = 1'b0;
    chk("hi_first_d0", {128'd0, m1_if.tdata}, {128'd0, {8{16'h1234}}});
    chk("hi_first_v0", {255'd0, m1_if.tvalid}, 256'd1);
    @(negedge clk);
    chk("hi_first_d1", {128'd0, m1_if.tdata}, {128'd0, {8{16'h5678}}});
    @(negedge clk);
    chk("hi_first_v2", {255'd0, m1_if.tvalid}, 256'd0);

    // Saturation of the 4-bit counter after 2^4+3 drop events
    m1_if.tready = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      s1_if.tvalid = 1'b1;
      s1_if.tdata  = word_of(i);
      @(negedge clk);
      s1_if.tvalid = 1'b0;
      resync1 = 1'b1;
      @(negedge clk);
      resync1 = 1'b0;
      if (i == 1)  chk("sat_first", 256'(drop_count1), 256'd1);
      if (i == 14) chk("sat_pre", 256'(drop_count1), 256'd14);
      if (i == 15) chk("sat_reach", 256'(drop_count1), 256'd15);
    end
    chk("sat_hold", 256'(drop_count1), 256'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
